// File: rtl/mp_add_pkg.sv
// Shared parameters and FSM state encoding for the sequential multi-precision adder.
package mp_add_pkg;

   localparam int unsigned WORD_W_DEF    = 16;
   localparam int unsigned NUM_WORDS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla16_slice.sv
// WORD_W-bit parallel-prefix carry-lookahead adder slice with carry-in and
// the MSB carry-in exposed for signed overflow detection.
module cla16_slice
   import mp_add_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF
) (
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              c_i,
   output logic [WORD_W-1:0] sum_o,
   output logic              c_o,
   output logic              c_msb_o
);

   localparam int unsigned LVLS = $clog2(WORD_W);

   logic [WORD_W-1:0] p0;
   logic [WORD_W:0]   c;

   // Kogge-Stone prefix: gg[i]/pp[i] become group generate/propagate over bits [i:0]
   always_comb begin : prefix
      logic [WORD_W-1:0] gg;
      logic [WORD_W-1:0] pp;
      logic [WORD_W-1:0] gn;
      logic [WORD_W-1:0] pn;
      gg = a_i & b_i;
      pp = a_i ^ b_i;
      gn = gg;
      pn = pp;
      for (int l = 0; l < int'(LVLS); l++) begin
         gn = gg;
         pn = pp;
         for (int i = 0; i < int'(WORD_W); i++) begin
            if (i >= (1 << l)) begin
               gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
               pn[i] = pp[i] & pp[i - (1 << l)];
            end
         end
         gg = gn;
         pp = pn;
      end
      c[0] = c_i;
      for (int i = 0; i < int'(WORD_W); i++) begin
         c[i+1] = gg[i] | (pp[i] & c_i);
      end
   end

   assign p0      = a_i ^ b_i;
   assign sum_o   = p0 ^ c[WORD_W-1:0];
   assign c_o     = c[WORD_W];
   assign c_msb_o = c[WORD_W-1];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision add/subtract: one WORD_W slice per cycle through a
// single shared lookahead slice, with valid/ready handshakes on both sides.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int unsigned WORD_W    = WORD_W_DEF,
   parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WORD_W*NUM_WORDS-1:0]   a_in,
   input  logic [WORD_W*NUM_WORDS-1:0]   b_in,
   input  logic                          sub,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WORD_W*NUM_WORDS-1:0]   sum_out,
   output logic                          carry_out,
   output logic                          ovf_out
);

   localparam int unsigned OP_W  = WORD_W * NUM_WORDS;
   localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [OP_W-1:0]   b_q, b_d;
   logic [OP_W-1:0]   sum_q, sum_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic [WORD_W-1:0] a_sl;
   logic [WORD_W-1:0] b_sl;
   logic [WORD_W-1:0] sl_sum;
   logic              sl_cout;
   logic              sl_cmsb;

   // Operand slice select for the current index
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sl = a_q[i*WORD_W +: WORD_W];
            b_sl = b_q[i*WORD_W +: WORD_W];
         end
      end
   end

   cla16_slice #(
      .WORD_W (WORD_W)
   ) u_slice (
      .a_i     (a_sl),
      .b_i     (b_sl),
      .c_i     (carry_q),
      .sum_o   (sl_sum),
      .c_o     (sl_cout),
      .c_msb_o (sl_cmsb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // RUN spends one extra cycle at idx == NUM_WORDS before DONE so the result
   // is flagged NUM_WORDS+1 edges after acceptance.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = a_in;
               b_d     = sub ? ~b_in : b_in;
               carry_d = sub;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (idx_q == IDX_W'(NUM_WORDS)) begin
               state_d = DONE;
            end else begin
               for (int i = 0; i < int'(NUM_WORDS); i++) begin
                  if (idx_q == IDX_W'(i)) sum_d[i*WORD_W +: WORD_W] = sl_sum;
               end
               carry_d = sl_cout;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                  cout_d = sl_cout;
                  ovf_d  = sl_cmsb ^ sl_cout;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum_out   = sum_q;
   assign carry_out = cout_q;
   assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq (64-bit default configuration).
module tb_mp_add_seq;

   localparam int unsigned OP_W  = 64;
   localparam int          LIMIT = 50;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [OP_W-1:0] a_in;
   logic [OP_W-1:0] b_in;
   logic            sub;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] sum_out;
   logic            carry_out;
   logic            ovf_out;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic            s;
      logic [OP_W-1:0] sum;
      logic            c;
      logic            ov;
   } vec_t;

   mp_add_seq #(
      .WORD_W    (16),
      .NUM_WORDS (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum_out   (sum_out),
      .carry_out (carry_out),
      .ovf_out   (ovf_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request; returns 1ns after the accepting edge
   task automatic issue(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic s);
      a_in = a; b_in = b; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
   endtask

   // Count edges until out_valid is seen; 0 means it never came
   task automatic wait_done(input int already, output int lat);
      lat = already;
      while (lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid === 1'b1) return;
      end
      lat = 0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; #2; rst = 1'b1; #1;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (sum_out !== '0 || carry_out !== 1'b0 || ovf_out !== 1'b0)
         $display("FAIL reset_outputs: sum=%h c=%b ov=%b, want zeros", sum_out, carry_out, ovf_out);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_arith();
      vec_t v[7];
      int   lat;
      v[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      v[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
      v[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      v[3] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      v[4] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
      v[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      v[6] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
      for (int k = 0; k < 7; k++) begin
         issue(v[k].a, v[k].b, v[k].s);
         wait_done(0, lat);
         total_cnt++;
         if (lat != 5) $display("FAIL arith%0d_latency: got %0d edges, want 5", k, lat);
         else pass_cnt++;
         total_cnt++;
         if (sum_out !== v[k].sum) $display("FAIL arith%0d_sum: got %h, want %h", k, sum_out, v[k].sum);
         else pass_cnt++;
         total_cnt++;
         if (carry_out !== v[k].c) $display("FAIL arith%0d_carry: got %b, want %b", k, carry_out, v[k].c);
         else pass_cnt++;
         total_cnt++;
         if (ovf_out !== v[k].ov) $display("FAIL arith%0d_ovf: got %b, want %b", k, ovf_out, v[k].ov);
         else pass_cnt++;
         release_result();
         total_cnt++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL arith%0d_release: out_valid=%b in_ready=%b, want 0/1", k, out_valid, in_ready);
         else pass_cnt++;
      end
   endtask

   task automatic test_stall();
      int lat;
      logic [OP_W-1:0] exp_sum = 64'h1234_5678_9ABC_DF00;
      issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      // Requests during RUN must be ignored and must not disturb the operands
      a_in = '1; b_in = '1; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      wait_done(2, lat);
      total_cnt++;
      if (lat != 5) $display("FAIL stall_latency: got %0d edges, want 5", lat);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL stall_hs%0d: out_valid=%b in_ready=%b, want 1/0", i, out_valid, in_ready);
         else pass_cnt++;
         total_cnt++;
         if (sum_out !== exp_sum || carry_out !== 1'b0 || ovf_out !== 1'b0)
            $display("FAIL stall_data%0d: sum=%h c=%b ov=%b, want %h/0/0", i, sum_out, carry_out, ovf_out, exp_sum);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
      release_result();
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat;
      // First operation: 0xFFFF_FFFF + 1
      issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      wait_done(0, lat);
      total_cnt++;
      if (sum_out !== 64'h0000_0001_0000_0000) $display("FAIL b2b_first_sum: got %h, want 0000000100000000", sum_out);
      else pass_cnt++;
      // Hold a new request through the DONE->IDLE edge: must not be taken there
      a_in = 64'd100; b_in = 64'd1; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL b2b_gap: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
      else pass_cnt++;
      wait_done(0, lat);
      total_cnt++;
      if (lat != 5) $display("FAIL b2b_latency: got %0d edges, want 5", lat);
      else pass_cnt++;
      total_cnt++;
      if (sum_out !== 64'd99 || carry_out !== 1'b1 || ovf_out !== 1'b0)
         $display("FAIL b2b_second: sum=%h c=%b ov=%b, want 63/1/0", sum_out, carry_out, ovf_out);
      else pass_cnt++;
      release_result();
   endtask

   task automatic test_reset_abort();
      int   lat;
      logic seen;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1; #1;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL abort_handshake: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (sum_out !== '0 || carry_out !== 1'b0 || ovf_out !== 1'b0)
         $display("FAIL abort_outputs: sum=%h c=%b ov=%b, want zeros", sum_out, carry_out, ovf_out);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL abort_no_valid: out_valid seen=%b, want 0", seen);
      else pass_cnt++;
      issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      wait_done(0, lat);
      total_cnt++;
      if (lat != 5) $display("FAIL abort_fresh_latency: got %0d edges, want 5", lat);
      else pass_cnt++;
      total_cnt++;
      if (sum_out !== 64'h2222_2222_2222_2211 || carry_out !== 1'b0 || ovf_out !== 1'b0)
         $display("FAIL abort_fresh_result: sum=%h c=%b ov=%b, want 2222222222222211/0/0",
                  sum_out, carry_out, ovf_out);
      else pass_cnt++;
      release_result();
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0; out_ready = 1'b0;
      test_reset();
      test_arith();
      test_stall();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
